cfg_write_arbiter: RTL and testbench
====================================

# cfg_write_arbiter

Round-robin arbiter that shares the single configuration write path (addr/data/valid pulse feeding the config splitter) between several requesters: the host control-register front end plus on-chip sources such as sequencers or self-test logic. Supports locked multi-beat sequences so that a group of related registers is updated without interleaving. The arbiter emits at most one registered config write per cycle.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (≥1); index 0 is the host front end.
- ADDR_BITS, 16, config register address width.
- DATA_BITS, 64, config data width.
- LOCK_TIMEOUT, 0, idle cycles before a held lock is forcibly released; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  requester i presents a write.
- req_ready  out  NUM_REQ  combinational grant; a beat is accepted when valid&ready.
- req_addr  in  NUM_REQ×ADDR_BITS  per-requester register address.
- req_data  in  NUM_REQ×DATA_BITS  per-requester data.
- req_lock  in  NUM_REQ  beat opens or continues a locked sequence.
- cfg_valid  out  1  one-cycle write pulse toward the splitter.
- cfg_addr  out  ADDR_BITS  write address.
- cfg_data  out  DATA_BITS  write data.
- lock_abort  out  1  one-cycle pulse when a lock is released by timeout.
- grant_count  out  NUM_REQ×32  accepted beats per requester (see Configuration).

## Operation
- State machine: IDLE and LOCKED (owner index held in a register).
- IDLE: eligible set = all i with req_valid[i]. The winner is the first eligible index searching upward from (last_grant+1) mod NUM_REQ, wrapping around. Only the winner gets req_ready. last_grant becomes the winner on acceptance.
- Accepted beat with req_lock=1 in IDLE moves to LOCKED with owner=winner.
- LOCKED: only the owner is eligible; req_ready=0 for all others, whether or not they are valid. An owner beat with lock=1 stays LOCKED. An owner beat with lock=0 is accepted and returns to IDLE; that beat is the last of the sequence.
- Timeout (LOCK_TIMEOUT>0): an idle counter counts LOCKED cycles without owner valid and resets on any owner beat. When it reaches LOCK_TIMEOUT, return to IDLE and pulse lock_abort. No write is emitted for the abort.
- The accepted beat is registered into cfg_addr/cfg_data with cfg_valid=1 for exactly one cycle. cfg_valid=0 in any cycle with no acceptance. cfg_addr/cfg_data hold their last value.
- Data is passed through unmodified; no strobe handling is done here.
- NUM_REQ=1: the arbiter degenerates to a register stage, and lock behaviour is unchanged.

## Timing
- Reset values: cfg_valid=0, cfg_addr=0, cfg_data=0, lock_abort=0, grant_count=0, state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), idle counter=0.
- Latency is 1 cycle from acceptance to cfg_valid. Throughput is 1 write/cycle, including back-to-back beats from different requesters.
- req_ready depends only on req_valid, state, owner and last_grant. It has no combinational path from cfg_*.
- Requesters hold valid/addr/data/lock stable until accepted.
- Reset asserted mid-lock drops the lock immediately. cfg_valid is 0 in the cycle after reset is sampled, and a beat presented during reset is not accepted.
- A timeout and an owner beat arriving in the same cycle: the beat wins, is accepted, and resets the counter; there is no abort.

## Configuration
- CFG_ARB_STATS_EN defined: grant_count[i] increments on each accepted beat of requester i and saturates at 2^32-1.
- Not defined: grant_count is tied to 0 and the counters are not synthesized.

## Test plan
- All requesters valid continuously with NUM_REQ=3, lock=0: grants 0,1,2,0,1,2 on consecutive cycles, cfg_valid high every cycle after the first acceptance, addresses match the requester order.
- Req1 sends 3 beats with lock=1,1,0 (addr 0x10,0x11,0x12) while req0 is valid: req0 is stalled; cfg writes 0x10,0x11,0x12 back-to-back, then req0's write.
- LOCK_TIMEOUT=4: req0 sends one beat with lock=1, then drops valid. lock_abort pulses after 4 idle cycles, and req1 (waiting) is granted the next cycle.
- Reset asserted while LOCKED with an owner beat pending: the beat is not emitted, state is IDLE afterwards, and the first post-reset grant goes to req0 when all are valid.
- With CFG_ARB_STATS_EN: 5 beats from req0 and 2 from req1 give grant_count = {2,5}. Forcing a counter to 0xFFFFFFFF plus one beat leaves it at 0xFFFFFFFF. Without the macro, grant_count=0.
- Single requester, data 0xDEADBEEF_CAFEF00D: cfg_data equals that value one cycle after acceptance, with cfg_valid high for exactly one cycle.

Source files
------------

// File: rtl/cfg_write_arbiter.sv
// cfg_write_arbiter: round-robin arbiter with locked multi-beat sequences onto one registered config write port.
// Define CFG_ARB_STATS_EN to build the per-requester saturating grant counters.
module cfg_write_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_BITS    = 16,
  parameter int DATA_BITS    = 64,
  parameter int LOCK_TIMEOUT = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic                           cfg_valid,
  output logic [ADDR_BITS-1:0]           cfg_addr,
  output logic [DATA_BITS-1:0]           cfg_data,
  output logic                           lock_abort,
  output logic [NUM_REQ*32-1:0]          grant_count
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_last, r_owner, w_win;
  logic [31:0] r_idle;
  logic w_any, w_acc, w_tmo, w_abort;
  // Descending scan so the nearest index after last_grant is assigned last and wins.
  always_comb begin
    w_win = r_owner;
    w_any = 1'b0;
    if (r_state == IDLE) begin
      for (int k = NUM_REQ; k >= 1; k--)
        if (req_valid[(int'(r_last) + k) % NUM_REQ]) begin
          w_win = IW'((int'(r_last) + k) % NUM_REQ);
          w_any = 1'b1;
        end
    end else begin
      w_any = req_valid[r_owner];
    end
    w_acc = w_any & rst_n;
    req_ready = '0;
    req_ready[w_win] = w_acc;
  end
  always_comb begin
    w_tmo = LOCK_TIMEOUT != 0 && r_state == LOCKED && !req_valid[r_owner] &&
            r_idle == 32'(LOCK_TIMEOUT - 1);
    w_abort = w_tmo;
    w_next = r_state == IDLE ? ((w_acc && req_lock[w_win]) ? LOCKED : IDLE)
           : (w_tmo || (w_acc && !req_lock[w_win])) ? IDLE : LOCKED;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= IW'(NUM_REQ - 1);
      r_owner    <= '0;
      r_idle     <= '0;
      cfg_valid  <= 1'b0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      lock_abort <= 1'b0;
    end else begin
      r_state    <= w_next;
      cfg_valid  <= w_acc;
      lock_abort <= w_abort;
      r_idle     <= (LOCK_TIMEOUT != 0 && r_state == LOCKED && !req_valid[r_owner] && !w_tmo)
                    ? r_idle + 32'd1 : '0;
      if (w_acc) begin
        r_last   <= w_win;
        r_owner  <= w_win;
        cfg_addr <= req_addr[w_win*ADDR_BITS +: ADDR_BITS];
        cfg_data <= req_data[w_win*DATA_BITS +: DATA_BITS];
      end
    end
  end
`ifdef CFG_ARB_STATS_EN
  logic [31:0] r_cnt [NUM_REQ];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      r_cnt[i] <= !rst_n ? '0
                : (w_acc && int'(w_win) == i && r_cnt[i] != '1) ? r_cnt[i] + 32'd1 : r_cnt[i];
  end
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_count[g*32 +: 32] = r_cnt[g];
  end
`else
  assign grant_count = '0;
`endif
endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb_cfg_write_arbiter: directed checks of arbitration, locking, timeout, reset, stats and single-requester mode.
module tb_cfg_write_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic [2:0] v, l, rdy;
  logic [47:0] a;
  logic [191:0] d;
  logic cv, ab;
  logic [15:0] ca;
  logic [63:0] cd;
  logic [95:0] gc;
  logic v1, l1, rdy1, cv1, ab1;
  logic [15:0] a1, ca1;
  logic [63:0] d1, cd1;
  logic [31:0] gc1;
  int n_chk = 0;
  int n_fail = 0;

  cfg_write_arbiter #(.NUM_REQ(3), .LOCK_TIMEOUT(4)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v), .req_ready(rdy), .req_addr(a), .req_data(d),
    .req_lock(l), .cfg_valid(cv), .cfg_addr(ca), .cfg_data(cd), .lock_abort(ab), .grant_count(gc));
  cfg_write_arbiter #(.NUM_REQ(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_addr(a1), .req_data(d1),
    .req_lock(l1), .cfg_valid(cv1), .cfg_addr(ca1), .cfg_data(cd1), .lock_abort(ab1), .grant_count(gc1));

  function automatic logic [63:0] dat(input logic [15:0] x);
    return {x, ~x, 16'h5A5A, x};
  endfunction
  task automatic put(input int i, input logic val, input logic [15:0] addr, input logic lk);
    v[i] = val;
    l[i] = lk;
    a[i*16 +: 16] = addr;
    d[i*64 +: 64] = dat(addr);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    put(0, 1, 16'h0070, 0); put(1, 1, 16'h0071, 0); put(2, 1, 16'h0072, 0);
    #1;
    n_chk++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", rdy); end
    tick;
    n_chk++; if (cv !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid: got %b expected 0", cv); end
    n_chk++; if (ca !== 16'h0) begin n_fail++; $display("FAIL reset_cfg_addr: got %h expected 0", ca); end
    n_chk++; if (cd !== 64'h0) begin n_fail++; $display("FAIL reset_cfg_data: got %h expected 0", cd); end
    n_chk++; if (ab !== 1'b0) begin n_fail++; $display("FAIL reset_lock_abort: got %b expected 0", ab); end
    n_chk++; if (gc !== 96'h0) begin n_fail++; $display("FAIL reset_grant_count: got %h expected 0", gc); end
    n_chk++; if (cv1 !== 1'b0) begin n_fail++; $display("FAIL reset_single_valid: got %b expected 0", cv1); end
    v = '0;
  endtask

  task automatic test_round_robin;
    logic [15:0] ea;
    rst_n = 1'b1;
    put(0, 1, 16'h0100, 0); put(1, 1, 16'h0101, 0); put(2, 1, 16'h0102, 0);
    for (int n = 0; n < 6; n++) begin
      ea = 16'h0100 + 16'(n % 3);
      #1;
      n_chk++; if (rdy !== 3'(1 << (n % 3))) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", n, rdy, 3'(1 << (n % 3))); end
      tick;
      n_chk++; if (cv !== 1'b1 || ca !== ea) begin n_fail++; $display("FAIL rr_write[%0d]: got v=%b a=%h expected v=1 a=%h", n, cv, ca, ea); end
      n_chk++; if (cd !== dat(ea)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", n, cd, dat(ea)); end
    end
    v = '0;
    tick;
    n_chk++; if (cv !== 1'b0 || ca !== 16'h0102) begin n_fail++; $display("FAIL rr_idle_hold: got v=%b a=%h expected v=0 a=0102", cv, ca); end
  endtask

  task automatic test_lock;
    put(0, 1, 16'h01FF, 0);
    tick;
    n_chk++; if (ca !== 16'h01FF) begin n_fail++; $display("FAIL lock_pre: got %h expected 01ff", ca); end
    put(0, 1, 16'h0200, 0);
    for (int n = 0; n < 3; n++) begin
      put(1, 1, 16'h0010 + 16'(n), n < 2);
      #1;
      n_chk++; if (rdy !== 3'b010) begin n_fail++; $display("FAIL lock_ready[%0d]: got %b expected 010", n, rdy); end
      tick;
      n_chk++; if (cv !== 1'b1 || ca !== 16'h0010 + 16'(n)) begin n_fail++; $display("FAIL lock_write[%0d]: got v=%b a=%h expected v=1 a=%h", n, cv, ca, 16'h0010 + 16'(n)); end
    end
    v[1] = 1'b0;
    #1;
    n_chk++; if (rdy !== 3'b001) begin n_fail++; $display("FAIL lock_release_ready: got %b expected 001", rdy); end
    tick;
    n_chk++; if (cv !== 1'b1 || ca !== 16'h0200) begin n_fail++; $display("FAIL lock_after: got v=%b a=%h expected v=1 a=0200", cv, ca); end
    n_chk++; if (ab !== 1'b0) begin n_fail++; $display("FAIL lock_no_abort: got %b expected 0", ab); end
    v = '0;
  endtask

  task automatic test_timeout;
    put(0, 1, 16'h0300, 1);
    tick;
    n_chk++; if (ca !== 16'h0300) begin n_fail++; $display("FAIL tmo_open: got %h expected 0300", ca); end
    v[0] = 1'b0;
    put(1, 1, 16'h0301, 0);
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_chk++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL tmo_stall[%0d]: got %b expected 000", k, rdy); end
      tick;
      n_chk++; if (ab !== (k == 4) || cv !== 1'b0) begin n_fail++; $display("FAIL tmo_abort[%0d]: got ab=%b v=%b expected ab=%b v=0", k, ab, cv, k == 4); end
    end
    n_chk++; if (rdy !== 3'b010) begin n_fail++; $display("FAIL tmo_regrant: got %b expected 010", rdy); end
    tick;
    n_chk++; if (cv !== 1'b1 || ca !== 16'h0301 || ab !== 1'b0) begin n_fail++; $display("FAIL tmo_next: got v=%b a=%h ab=%b expected v=1 a=0301 ab=0", cv, ca, ab); end
    v = '0;
    put(0, 1, 16'h0400, 1);
    tick;
    v[0] = 1'b0;
    repeat (3) tick;
    put(0, 1, 16'h0401, 0);
    #1;
    n_chk++; if (rdy !== 3'b001) begin n_fail++; $display("FAIL tmo_race_ready: got %b expected 001", rdy); end
    tick;
    n_chk++; if (cv !== 1'b1 || ca !== 16'h0401 || ab !== 1'b0) begin n_fail++; $display("FAIL tmo_race_beat: got v=%b a=%h ab=%b expected v=1 a=0401 ab=0", cv, ca, ab); end
    v[0] = 1'b0;
    tick;
    n_chk++; if (ab !== 1'b0) begin n_fail++; $display("FAIL tmo_race_late: got %b expected 0", ab); end
  endtask

  task automatic test_reset_mid_lock;
    put(1, 1, 16'h0500, 1);
    #1;
    n_chk++; if (rdy !== 3'b010) begin n_fail++; $display("FAIL rml_open_ready: got %b expected 010", rdy); end
    tick;
    put(1, 1, 16'h0501, 1);
    rst_n = 1'b0;
    #1;
    n_chk++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL rml_ready_in_reset: got %b expected 000", rdy); end
    tick;
    n_chk++; if (cv !== 1'b0 || ca !== 16'h0) begin n_fail++; $display("FAIL rml_no_emit: got v=%b a=%h expected v=0 a=0000", cv, ca); end
    rst_n = 1'b1;
    put(0, 1, 16'h0600, 0); put(1, 1, 16'h0601, 0); put(2, 1, 16'h0602, 0);
    #1;
    n_chk++; if (rdy !== 3'b001) begin n_fail++; $display("FAIL rml_first_grant: got %b expected 001", rdy); end
    tick;
    n_chk++; if (cv !== 1'b1 || ca !== 16'h0600) begin n_fail++; $display("FAIL rml_first_write: got v=%b a=%h expected v=1 a=0600", cv, ca); end
    v = '0;
    tick;
  endtask

  task automatic test_stats;
    logic [95:0] eg;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_chk++; if (gc !== 96'h0) begin n_fail++; $display("FAIL stats_clear: got %h expected 0", gc); end
    put(0, 1, 16'h0700, 0);
    repeat (5) tick;
    v[0] = 1'b0;
    put(1, 1, 16'h0701, 0);
    repeat (2) tick;
    v[1] = 1'b0;
    tick;
`ifdef CFG_ARB_STATS_EN
    eg = {32'd0, 32'd2, 32'd5};
`else
    eg = '0;
`endif
    n_chk++; if (gc !== eg) begin n_fail++; $display("FAIL stats_count: got %h expected %h", gc, eg); end
`ifdef CFG_ARB_STATS_EN
    u3.r_cnt[0] = 32'hFFFF_FFFF;
    eg = {32'd0, 32'd2, 32'hFFFF_FFFF};
`endif
    put(0, 1, 16'h0702, 0);
    tick;
    v[0] = 1'b0;
    tick;
    n_chk++; if (gc !== eg) begin n_fail++; $display("FAIL stats_saturate: got %h expected %h", gc, eg); end
  endtask

  task automatic test_single;
    v1 = 1'b1; l1 = 1'b0; a1 = 16'h0ABC; d1 = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    n_chk++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", rdy1); end
    tick;
    v1 = 1'b0;
    n_chk++; if (cv1 !== 1'b1 || cd1 !== 64'hDEAD_BEEF_CAFE_F00D || ca1 !== 16'h0ABC) begin n_fail++; $display("FAIL single_write: got v=%b a=%h d=%h expected v=1 a=0abc d=deadbeefcafef00d", cv1, ca1, cd1); end
    tick;
    n_chk++; if (cv1 !== 1'b0 || cd1 !== 64'hDEAD_BEEF_CAFE_F00D) begin n_fail++; $display("FAIL single_pulse: got v=%b d=%h expected v=0 d=deadbeefcafef00d", cv1, cd1); end
  endtask

  initial begin
    rst_n = 1'b0;
    v = '0; l = '0; a = '0; d = '0;
    v1 = 1'b0; l1 = 1'b0; a1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_round_robin;
    test_lock;
    test_timeout;
    test_reset_mid_lock;
    test_stats;
    test_single;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
